// File: rtl/line_pixel_fetch.sv
// line_pixel_fetch: prefetches each active line's pixel words into a FIFO during blanking and emits one 8-bit CLUT index per pixel strobe.
module line_pixel_fetch #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              new_line,
  input  logic              new_pixel,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [11:0]       line_stride,
  input  logic [9:0]        words_per_line,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  output logic              underflow,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH_WAIT} state_t;
  state_t state, state_nx;
  logic [15:0] fifo [DEPTH];
  logic [15:0] head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, outstanding, discard_cnt, out_nx;
  logic [CW:0] fill;
  logic [ADDR_W-1:0] line_addr, fetch_addr, nxt_addr, base_addr;
  logic [9:0] remaining, nxt_rem;
  logic nxt_go, req_hold, byte_sel, ack, rv, drop, push, pop, pending, go;
  // outstanding keeps counting words already marked for discard, so the FIFO-space test stays conservative
  always_comb begin
    base_addr = new_frame ? frame_base : line_addr;
    fill = {1'b0, count} + {1'b0, outstanding};
    mem_req = req_hold || (state == FETCH && remaining != 10'd0 && fill < (CW+1)'(DEPTH));
    mem_addr = fetch_addr;
    busy = state != IDLE;
    ack = mem_req && mem_ack;
    pending = mem_req && !mem_ack;
    rv = mem_rvalid && outstanding != '0;
    drop = rv && discard_cnt != '0;
    push = rv && !drop && !new_line;
    head = fifo[rptr];
    pop = new_pixel && count != '0 && !byte_sel;
    go = !vblank && words_per_line != 10'd0;
    out_nx = outstanding + CW'(ack) - CW'(rv);
    state_nx = state;
    if (new_line) state_nx = pending ? FLUSH_WAIT : go ? FETCH : IDLE;
    else if (ack && state == FLUSH_WAIT) state_nx = nxt_go ? FETCH : IDLE;
    else if (ack && remaining == 10'd1) state_nx = IDLE;
  end
  always_ff @(posedge clk) if (push) fifo[wptr] <= mem_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      line_addr   <= '0;
      fetch_addr  <= '0;
      nxt_addr    <= '0;
      remaining   <= '0;
      nxt_rem     <= '0;
      nxt_go      <= 1'b0;
      req_hold    <= 1'b0;
      outstanding <= '0;
      discard_cnt <= '0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      byte_sel    <= 1'b1;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_nx;
      req_hold    <= pending;
      outstanding <= out_nx;
      count       <= new_line ? '0 : count + CW'(push) - CW'(pop);
      wptr        <= new_line ? '0 : wptr + AW'(push);
      rptr        <= new_line ? '0 : rptr + AW'(pop);
      pixel_valid <= new_pixel;
      underflow   <= (underflow && !new_frame) || (new_pixel && count == '0);
      byte_sel    <= new_line ? 1'b1 : (new_pixel && count != '0) ? !byte_sel : byte_sel;
      if (new_pixel) pixel <= count == '0 ? 8'h00 : byte_sel ? head[15:8] : head[7:0];
      if (new_frame) line_addr <= frame_base;
      if (new_line) begin
        discard_cnt <= out_nx;
        if (!vblank) line_addr <= base_addr + ADDR_W'(line_stride);
        // an un-acked request must complete at its old address, so the new line's parameters wait aside
        if (pending) begin
          nxt_addr <= base_addr;
          nxt_rem  <= vblank ? 10'd0 : words_per_line;
          nxt_go   <= go;
        end else begin
          fetch_addr <= base_addr;
          remaining  <= vblank ? 10'd0 : words_per_line;
        end
      end else begin
        discard_cnt <= discard_cnt - CW'(drop) + CW'(ack && state == FLUSH_WAIT);
        if (ack && state == FLUSH_WAIT) begin
          fetch_addr <= nxt_addr;
          remaining  <= nxt_rem;
        end else if (ack) begin
          fetch_addr <= fetch_addr + ADDR_W'(1);
          remaining  <= remaining - 10'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_line_pixel_fetch.sv
// tb_line_pixel_fetch: directed and randomized checks of line_pixel_fetch against a queue-based transaction model.
module tb_line_pixel_fetch;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 1;
  logic new_frame = 0, new_line = 0, new_pixel = 0, vblank = 0;
  logic [21:0] frame_base = 0;
  logic [11:0] line_stride = 0;
  logic [9:0] words_per_line = 0;
  logic mem_req, mem_ack = 0, mem_rvalid = 0;
  logic [21:0] mem_addr;
  logic [15:0] mem_rdata = 0;
  logic [7:0] pixel;
  logic pixel_valid, underflow, busy;
  int tests = 0, fails = 0;

  line_pixel_fetch #(.DEPTH(DEPTH), .ADDR_W(22)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .new_line(new_line),
    .new_pixel(new_pixel), .vblank(vblank), .frame_base(frame_base),
    .line_stride(line_stride), .words_per_line(words_per_line),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .pixel(pixel),
    .pixel_valid(pixel_valid), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_data(input logic [21:0] a);
    if (a >= 22'h100 && a < 22'h104) return 16'h1122 + 16'(a - 22'h100) * 16'h2222;
    return {a[7:0] + 8'h5A, a[15:8] ^ a[7:0]};
  endfunction

  // transaction model: FIFO contents and in-flight reads (with a drop flag) as queues
  logic [15:0] mq[$];
  bit infl[$];
  logic [21:0] m_line, m_faddr, m_naddr;
  int m_rem, m_nrem;
  bit m_fetch, m_fw, m_ngo, m_held, m_hi, m_uf, m_pv;
  logic [7:0] m_pix;

  function automatic bit m_req_f();
    return m_held || (m_fetch && m_rem > 0 && (mq.size() + infl.size()) < DEPTH);
  endfunction

  task automatic m_init();
    mq.delete(); infl.delete();
    m_line = 0; m_faddr = 0; m_naddr = 0; m_rem = 0; m_nrem = 0;
    m_fetch = 0; m_fw = 0; m_ngo = 0; m_held = 0; m_hi = 1; m_uf = 0; m_pv = 0; m_pix = 0;
  endtask

  task automatic m_step();
    bit req, ack, d;
    logic [21:0] base;
    logic [15:0] h;
    req = m_req_f();
    ack = req && mem_ack;
    if (new_frame) begin m_line = frame_base; m_uf = 0; end
    m_pv = new_pixel;
    if (new_pixel) begin
      if (mq.size() > 0) begin
        h = mq[0];
        m_pix = m_hi ? h[15:8] : h[7:0];
        if (!m_hi) void'(mq.pop_front());
        m_hi = !m_hi;
      end else begin
        m_pix = 0; m_uf = 1;
      end
    end
    if (mem_rvalid && infl.size() > 0) begin
      d = infl.pop_front();
      if (!d && !new_line) mq.push_back(mem_rdata);
    end
    if (ack) begin
      infl.push_back(m_fw);
      if (m_fw) begin
        m_fw = 0; m_faddr = m_naddr; m_rem = m_nrem; m_fetch = m_ngo;
      end else begin
        m_faddr = m_faddr + 22'd1; m_rem--;
        if (m_rem == 0) m_fetch = 0;
      end
    end
    m_held = req && !mem_ack;
    if (new_line) begin
      mq.delete(); m_hi = 1;
      foreach (infl[i]) infl[i] = 1'b1;
      base = m_line;
      if (!vblank) m_line = m_line + 22'(line_stride);
      if (req && !mem_ack) begin
        m_fw = 1; m_fetch = 0; m_naddr = base;
        m_nrem = vblank ? 0 : int'(words_per_line);
        m_ngo = !vblank && words_per_line != 0;
      end else begin
        m_fw = 0; m_faddr = base;
        m_rem = vblank ? 0 : int'(words_per_line);
        m_fetch = !vblank && words_per_line != 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) m_init(); else m_step();
  end

  // memory: in-order responses, fixed latency per request
  logic [21:0] rq[$];
  int dq[$];
  logic [21:0] alog[$];
  int cyc = 0, lat = 2;
  initial forever begin
    @(posedge clk);
    if (reset) begin
      rq.delete(); dq.delete(); cyc = 0;
    end else begin
      cyc++;
      if (mem_req && mem_ack) begin
        rq.push_back(mem_addr); dq.push_back(cyc + lat - 1); alog.push_back(mem_addr);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    mem_rvalid = 0;
    if (!reset && dq.size() > 0 && dq[0] <= cyc) begin
      mem_rvalid = 1;
      mem_rdata = mem_data(rq.pop_front());
      void'(dq.pop_front());
    end
  end

  logic [7:0] cap[$];
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      bit er;
      er = m_req_f();
      chk("mem_req", 32'(mem_req), 32'(er));
      if (er) chk("mem_addr", 32'(mem_addr), 32'(m_faddr));
      chk("busy", 32'(busy), 32'(m_fetch || m_fw));
      chk("pixel_valid", 32'(pixel_valid), 32'(m_pv));
      if (m_pv) chk("pixel", 32'(pixel), 32'(m_pix));
      chk("underflow", 32'(underflow), 32'(m_uf));
      if (pixel_valid) cap.push_back(pixel);
    end
  end

  bit ack_rand = 0;
  int ack_pct = 100;
  task automatic step();
    @(negedge clk);
    new_frame = 0; new_line = 0; new_pixel = 0;
    if (ack_rand) mem_ack = int'($urandom_range(99)) < ack_pct;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_pixel"}, 32'(pixel), 0);
    chk({tag, "_underflow"}, 32'(underflow), 0);
  endtask

  initial begin
    logic [7:0] exp_pix [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 0;
    // basic line fetch and pixel unpacking
    ack_rand = 1; ack_pct = 100; lat = 2;
    alog.delete(); cap.delete();
    step(); new_frame = 1; frame_base = 22'h100; line_stride = 12'h030; words_per_line = 10'd4;
    step(); new_line = 1; vblank = 0;
    repeat (12) step();
    for (int i = 0; i < 8; i++) begin step(); new_pixel = 1; end
    repeat (3) step();
    chk("line1_acks", 32'(alog.size()), 4);
    for (int i = 0; i < 4 && i < alog.size(); i++) chk("line1_addr", 32'(alog[i]), 32'h100 + 32'(i));
    chk("line1_npix", 32'(cap.size()), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk("line1_pixel", 32'(cap[i]), 32'(exp_pix[i]));
    chk("line1_underflow", 32'(underflow), 0);
    // line address stepping and frame restart
    alog.delete();
    step(); new_line = 1;
    repeat (10) step();
    step(); new_line = 1;
    repeat (10) step();
    step(); new_frame = 1;
    step(); new_line = 1;
    repeat (10) step();
    chk("stride_acks", 32'(alog.size()), 12);
    if (alog.size() >= 12) begin
      chk("line2_addr", 32'(alog[0]), 32'h130);
      chk("line3_addr", 32'(alog[4]), 32'h160);
      chk("frame_restart_addr", 32'(alog[8]), 32'h100);
    end
    // FIFO backpressure
    alog.delete();
    step(); new_line = 1; words_per_line = 10'd40;
    repeat (30) step();
    chk("bp_acks", 32'(alog.size()), 16);
    chk("bp_req_low", 32'(mem_req), 0);
    step(); new_pixel = 1;
    step(); new_pixel = 1;
    repeat (5) step();
    chk("bp_resume_acks", 32'(alog.size()), 17);
    chk("bp_req_low2", 32'(mem_req), 0);
    // empty-line fetch disable and underflow
    step(); new_line = 1; words_per_line = 10'd0;
    repeat (3) step();
    chk("w0_busy", 32'(busy), 0);
    chk("w0_req", 32'(mem_req), 0);
    step(); new_pixel = 1;
    step();
    chk("uf_valid", 32'(pixel_valid), 1);
    chk("uf_pixel", 32'(pixel), 0);
    chk("uf_flag", 32'(underflow), 1);
    repeat (3) step();
    chk("uf_sticky", 32'(underflow), 1);
    step(); new_frame = 1;
    step();
    chk("uf_cleared", 32'(underflow), 0);
    // flush with 3 outstanding and one pending request
    ack_rand = 0; lat = 8; alog.delete();
    step(); mem_ack = 1; new_frame = 1; new_line = 1; frame_base = 22'h200; line_stride = 12'h040; words_per_line = 10'd8;
    repeat (3) step();
    step(); mem_ack = 0;
    step(); new_line = 1;
    step();
    chk("fw_busy", 32'(busy), 1);
    chk("fw_req", 32'(mem_req), 1);
    chk("fw_addr", 32'(mem_addr), 32'h203);
    step(); mem_ack = 1;
    step();
    chk("fw_next_req", 32'(mem_req), 1);
    chk("fw_next_addr", 32'(mem_addr), 32'h240);
    ack_rand = 1; ack_pct = 100;
    repeat (25) step();
    chk("fw_alog_n", 32'(alog.size()), 12);
    if (alog.size() >= 5) begin
      chk("fw_pending_addr", 32'(alog[3]), 32'h203);
      chk("fw_first_new_addr", 32'(alog[4]), 32'h240);
    end
    cap.delete();
    step(); new_pixel = 1;
    step(); new_pixel = 1;
    repeat (3) step();
    chk("fw_npix", 32'(cap.size()), 2);
    if (cap.size() >= 2) begin
      chk("fw_pix0", 32'(cap[0]), 32'h9A);
      chk("fw_pix1", 32'(cap[1]), 32'h42);
    end
    // vblank line does not fetch
    lat = 2;
    step(); vblank = 1; words_per_line = 10'd4; new_line = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("vb_req", 32'(mem_req), 0);
      chk("vb_busy", 32'(busy), 0);
    end
    step(); new_pixel = 1;
    step();
    chk("pre_reset_uf", 32'(underflow), 1);
    // asynchronous reset during FETCH
    ack_rand = 0;
    step(); mem_ack = 0; vblank = 0; words_per_line = 10'd40; new_line = 1;
    step();
    step();
    chk("pre_reset_req", 32'(mem_req), 1);
    #2 reset = 1;
    #1 chk_zero("async_reset");
    step(); reset = 0;
    // randomized operation
    ack_rand = 1;
    for (int ln = 0; ln < 60; ln++) begin
      step();
      if (ln % 6 == 0) begin new_frame = 1; frame_base = 22'($urandom); end
      line_stride = 12'($urandom);
      words_per_line = 10'($urandom_range(22));
      vblank = $urandom_range(4) == 0;
      new_line = 1;
      ack_pct = int'($urandom_range(40, 100));
      lat = int'($urandom_range(1, 6));
      repeat ($urandom_range(6, 20)) step();
      repeat (40) begin step(); new_pixel = $urandom_range(99) < 55; end
    end
    repeat (20) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
